// File: rtl/aes_byte_sequencer.sv
// Sequencer around an 8-bit serial AES-128 core: gathers a key/plaintext block,
// restarts and feeds the core, captures the ciphertext and drains it downstream.
module aes_byte_sequencer #(
    parameter int CORE_LAT = 180,
    parameter int RST_CYC  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_key,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       core_rst_n,
    output logic [7:0] core_key,
    output logic [7:0] core_din,
    input  logic [7:0] core_dout,
    output logic       busy
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RST  = 3'd1;
    localparam logic [2:0] S_LOAD = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_CAPT = 3'd4;

    localparam int WAIT_CYC = CORE_LAT - 16;
    localparam int WAIT_END = (WAIT_CYC > 0) ? WAIT_CYC - 1 : 0;
    localparam int RST_END  = (RST_CYC > 0) ? RST_CYC - 1 : 0;
    localparam int PH_MAX   = (CORE_LAT > RST_CYC) ? CORE_LAT : RST_CYC;
    localparam int PH_W     = $clog2(PH_MAX + 1);

    logic [2:0]       state;
    logic [PH_W-1:0]  ph_cnt;
    logic             ph_last;
    logic [15:0][7:0] key_buf;
    logic [15:0][7:0] din_buf;
    logic [15:0][7:0] out_buf;
    logic [3:0]       in_cnt;
    logic [3:0]       out_cnt;
    logic             in_full;
    logic             out_full;
    logic             in_acc;
    logic             out_take;
    logic             start;
    logic             load_done;
    logic             capt_done;

    assign in_ready  = rst_n & ~in_full;
    assign in_acc    = in_valid & in_ready;
    assign out_valid = out_full;
    assign out_last  = out_full & (out_cnt == 4'd15);
    assign out_take  = out_full & out_ready;
    assign busy      = (state != S_IDLE) | out_full;

    // Look ahead at the 16th input beat and the final output beat so a block
    // can start the cycle right after either event rather than one later.
    assign start = ena
                 & (in_full | (in_acc & (in_cnt == 4'd15)))
                 & (~out_full | (out_take & (out_cnt == 4'd15)));

    assign load_done = (state == S_LOAD) & ph_last;
    assign capt_done = (state == S_CAPT) & ph_last;

    assign core_key = (state == S_LOAD) ? key_buf[ph_cnt[3:0]] : 8'h00;
    assign core_din = (state == S_LOAD) ? din_buf[ph_cnt[3:0]] : 8'h00;

    always_comb begin
        ph_last = 1'b0;
        case (state)
            S_RST:  ph_last = (ph_cnt == PH_W'(RST_END));
            S_LOAD: ph_last = (ph_cnt == PH_W'(15));
            S_WAIT: ph_last = (ph_cnt == PH_W'(WAIT_END));
            S_CAPT: ph_last = (ph_cnt == PH_W'(15));
            default: ph_last = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            ph_cnt     <= '0;
            core_rst_n <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_RST;
                        ph_cnt     <= '0;
                        core_rst_n <= 1'b0;
                    end
                end
                S_RST: begin
                    if (ph_last) begin
                        state      <= S_LOAD;
                        ph_cnt     <= '0;
                        core_rst_n <= 1'b1;
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end
                S_LOAD: begin
                    if (ph_last) begin
                        state  <= (WAIT_CYC == 0) ? S_CAPT : S_WAIT;
                        ph_cnt <= '0;
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (ph_last) begin
                        state  <= S_CAPT;
                        ph_cnt <= '0;
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end
                S_CAPT: begin
                    if (ph_last) begin
                        state  <= S_IDLE;
                        ph_cnt <= '0;
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    ph_cnt <= '0;
                end
            endcase
        end
    end

    // in_full only sets while not full and only clears while full, never both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_cnt  <= '0;
            in_full <= 1'b0;
        end else begin
            if (in_acc) begin
                in_cnt <= in_cnt + 1'b1;
                if (in_cnt == 4'd15) in_full <= 1'b1;
            end
            if (load_done) in_full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (in_acc) begin
            key_buf[in_cnt] <= in_key;
            din_buf[in_cnt] <= in_data;
        end
        if (state == S_CAPT) out_buf[ph_cnt[3:0]] <= core_dout;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_full <= 1'b0;
            out_cnt  <= '0;
            out_data <= 8'h00;
        end else if (capt_done) begin
            out_full <= 1'b1;
            out_cnt  <= '0;
            out_data <= out_buf[0];
        end else if (out_take) begin
            if (out_cnt == 4'd15) begin
                out_full <= 1'b0;
                out_cnt  <= '0;
                out_data <= 8'h00;
            end else begin
                out_cnt  <= out_cnt + 1'b1;
                out_data <= out_buf[out_cnt + 4'd1];
            end
        end
    end

endmodule
